// File: rtl/fetch_queue.sv
// IF->ID decoupling queue: circular store plus registered output stage; 1-cycle IF->ID latency.
// Backpressure: STALL holds the output stage; Full_OUT asks IF to stall; pushes that still arrive are dropped and flagged in Overflow_OUT.
module fetch_queue_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clr,
  input  logic                         push_vld,
  input  logic [W-1:0]                 push_dat,
  input  logic                         pop_vld,
  output logic [W-1:0]                 head_dat,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_vld) begin
      mem_d[wr_ptr_q] = push_dat;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop_vld) rd_ptr_d = rd_ptr_q + 1'b1;
    if (push_vld && !pop_vld)      count_d = count_q + 1'b1;
    else if (!push_vld && pop_vld) count_d = count_q - 1'b1;
  end

  // Storage contents need no reset; only pointers and count are cleared.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_dat = mem_q[rd_ptr_q];
  assign count    = count_q;
endmodule

module fetch_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int PRED_W = 2
) (
  input  logic                        CLK,
  input  logic                        RESET,
  input  logic                        FLUSH,
  input  logic                        Redirect_IN,
  input  logic                        Instr_Valid_IF,
  input  logic [DATA_W-1:0]           Instr1_IF,
  input  logic [DATA_W-1:0]           Instr_PC_IF,
  input  logic [DATA_W-1:0]           Instr_PC_Plus4_IF,
  input  logic                        Branch_prediction_IN,
  input  logic [PRED_W-1:0]           Branch_predictions_IN,
  input  logic                        STALL,
  output logic [DATA_W-1:0]           Instr1_OUT,
  output logic [DATA_W-1:0]           Instr_PC_OUT,
  output logic [DATA_W-1:0]           Instr_PC_Plus4,
  output logic                        Branch_prediction_OUT,
  output logic [PRED_W-1:0]           Branch_predictions_OUT,
  output logic                        Instr_Valid_OUT,
  output logic                        Full_OUT,
  output logic [$clog2(DEPTH+1)-1:0]  Count_OUT,
  output logic                        Overflow_OUT
);
  localparam int CNT_W = $clog2(DEPTH+1);

  typedef struct packed {
    logic [DATA_W-1:0] instr;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] pc4;
    logic              taken;
    logic [PRED_W-1:0] preds;
  } entry_t;

  entry_t           in_dat, head_dat;
  entry_t           out_dat_q, out_dat_d;
  logic             out_vld_q, out_vld_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] count;
  logic             full, empty;
  logic             push_req, push_acc, pop_vld, bypass, store_vld, drop;

  assign in_dat = '{instr: Instr1_IF, pc: Instr_PC_IF, pc4: Instr_PC_Plus4_IF,
                    taken: Branch_prediction_IN, preds: Branch_predictions_IN};

  assign full      = (count == CNT_W'(DEPTH));
  assign empty     = (count == '0);
  assign push_req  = Instr_Valid_IF && !Redirect_IN;
  assign pop_vld   = !STALL && !empty;
  // A full queue still accepts when the head leaves in the same cycle.
  assign push_acc  = push_req && (!full || pop_vld);
  assign drop      = push_req && !push_acc;
  assign bypass    = !STALL && empty && push_acc;
  assign store_vld = push_acc && !bypass;

  fetch_queue_fifo #(.DEPTH(DEPTH), .W($bits(entry_t))) u_store (
    .clk      (CLK),
    .rst_n    (RESET),
    .clr      (FLUSH),
    .push_vld (store_vld && !FLUSH),
    .push_dat (in_dat),
    .pop_vld  (pop_vld && !FLUSH),
    .head_dat (head_dat),
    .count    (count)
  );

  always_comb begin
    out_dat_d = out_dat_q;
    out_vld_d = out_vld_q;
    ovf_d     = ovf_q | drop;
    if (!STALL) begin
      if (pop_vld) begin
        out_dat_d = head_dat;
        out_vld_d = 1'b1;
      end else if (bypass) begin
        out_dat_d = in_dat;
        out_vld_d = 1'b1;
      end else begin
        out_dat_d = '0;
        out_vld_d = 1'b0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET || FLUSH) begin
      out_dat_q <= '0;
      out_vld_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      out_dat_q <= out_dat_d;
      out_vld_q <= out_vld_d;
      ovf_q     <= ovf_d;
    end
  end

  assign Instr1_OUT             = out_dat_q.instr;
  assign Instr_PC_OUT           = out_dat_q.pc;
  assign Instr_PC_Plus4         = out_dat_q.pc4;
  assign Branch_prediction_OUT  = out_dat_q.taken;
  assign Branch_predictions_OUT = out_dat_q.preds;
  assign Instr_Valid_OUT        = out_vld_q;
  assign Full_OUT               = full;
  assign Count_OUT              = count;
  assign Overflow_OUT           = ovf_q;
endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Parametrised IF→ID decoupling buffer; successor to the single-entry IF/ID pipeline register.
- Holds up to DEPTH fetched instructions with their PC, PC+4 and branch-prediction bits in a circular FIFO, followed by a registered output stage feeding ID.
- Absorbs ID stalls without stalling IF until full.
- Supports flush, wrong-path squash of the incoming fetch, and an empty-queue bypass that preserves the old one-cycle latency.

Parameters:
DEPTH, 4, storage entries; power of two, >=2
DATA_W, 32, instruction/PC width
PRED_W, 2, width of Branch_predictions field

Ports:
CLK  in  1  clock; all state updates on posedge
RESET  in  1  synchronous reset, active-low; sampled on posedge CLK
FLUSH  in  1  discard all queued entries and the output stage
Redirect_IN  in  1  squash this cycle's incoming fetch (wrong path)
Instr_Valid_IF  in  1  push request from IF
Instr1_IF  in  DATA_W  fetched instruction
Instr_PC_IF  in  DATA_W  address of fetched instruction
Instr_PC_Plus4_IF  in  DATA_W  address of next instruction
Branch_prediction_IN  in  1  predicted-taken flag
Branch_predictions_IN  in  PRED_W  predictor state
STALL  in  1  ID stall; hold output stage
Instr1_OUT  out  DATA_W  instruction to ID
Instr_PC_OUT  out  DATA_W  its PC
Instr_PC_Plus4  out  DATA_W  its PC+4
Branch_prediction_OUT  out  1  its taken flag
Branch_predictions_OUT  out  PRED_W  its predictor state
Instr_Valid_OUT  out  1  output stage holds a real instruction
Full_OUT  out  1  storage count == DEPTH; IF must stall
Count_OUT  out  $clog2(DEPTH+1)  storage entries occupied (output stage excluded)
Overflow_OUT  out  1  sticky: a push was dropped

Behaviour:
- Reset: RESET==0 at posedge clears all outputs to 0, head/tail pointers to 0, count to 0, Overflow_OUT to 0. Storage contents are don't-care.
- Priority per edge: RESET > FLUSH > normal operation.
- FLUSH: same clearing as reset, except Overflow_OUT is also cleared. The push presented in the same cycle is discarded.
- Push accepted iff Instr_Valid_IF && !Redirect_IN && (count<DEPTH || pop).
  - Redirect_IN with Instr_Valid_IF drops the push silently; Overflow_OUT is not set.
- Pop (storage head → output stage) iff !STALL && count>0.
  - Output stage loads the head entry; Instr_Valid_OUT <= 1.
- Bypass: if !STALL && count==0 && push accepted, the incoming fetch loads the output stage directly and is not written to storage. Latency IF→output is 1 cycle.
- !STALL && count==0 && no push: output stage loads a bubble (all fields 0, Instr_Valid_OUT=0).
- STALL==1: output stage holds all fields unchanged. An accepted push is written at tail.
- Simultaneous push+pop with count>0: count unchanged; both pointers advance.
- Push+pop when count==DEPTH: accepted; the freed head slot is reused via tail wrap.
- Push request with count==DEPTH && !pop && !Redirect_IN: dropped; Overflow_OUT <= 1 (sticky).
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Count saturates by construction at 0..DEPTH.
- Full_OUT and Count_OUT reflect registered count after the edge. Full_OUT = (count==DEPTH).
- FIFO order strictly preserved. No entry is output twice; no accepted entry is lost except by FLUSH/RESET.

Test Plan:
- Reset mid-operation: fill 3 entries, drop RESET for one edge → next cycle all outputs 0, Count_OUT=0, Full_OUT=0. Reset asserted without a CLK edge changes nothing.
- Bypass latency: STALL=0, push PC=0x00400000 instr=0x8C080004 → one edge later Instr_PC_OUT=0x00400000, Instr1_OUT=0x8C080004, Instr_Valid_OUT=1, Count_OUT=0.
- Stall fill/drain with DEPTH=4: hold STALL=1, push PCs 0x100,0x104,0x108,0x10C,0x110 → Full_OUT=1 after 4th; 5th dropped with Overflow_OUT=1. Release STALL → outputs 0x100..0x10C on consecutive cycles, then bubble with Instr_Valid_OUT=0.
- Full with simultaneous push+pop: count=4, STALL=0, push 0x200 → Count_OUT stays 4, Overflow_OUT=0. 0x200 emerges after the four older entries (tail wrap).
- FLUSH with push: count=2, FLUSH=1 and push 0x300 → next cycle Count_OUT=0, Instr_Valid_OUT=0, Instr1_OUT=0. 0x300 never appears.
- Redirect squash: count=0, Redirect_IN=1 with push 0x400 → Instr_Valid_OUT=0, Count_OUT=0, Overflow_OUT=0. The following non-redirect push of 0x404 with Branch_predictions_IN=2'b10 appears next cycle with Branch_predictions_OUT=2'b10.
